// File: rtl/mem_window_sched_if.sv
// rtl/mem_window_sched_if.sv - controller/memory-side signal bundle for mem_window_sched
// err exists only when WIN_BOUND_CHK_EN is defined.
interface mem_window_sched_if #(
  parameter int ADDR_WIDTH   = 4,
  parameter int CNT_WIDTH    = 4,
  parameter int STRIDE_WIDTH = 3
) ();
  logic                    start;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic [STRIDE_WIDTH-1:0] stride;
  logic [CNT_WIDTH-1:0]    num_win;
  logic                    stall;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    win_valid;
  logic [CNT_WIDTH-1:0]    win_idx;
  logic                    busy;
  logic                    done;
`ifdef WIN_BOUND_CHK_EN
  logic                    err;

  modport master (
    output start, base_addr, stride, num_win, stall,
    input  addr, win_valid, win_idx, busy, done, err
  );
  modport slave (
    input  start, base_addr, stride, num_win, stall,
    output addr, win_valid, win_idx, busy, done, err
  );
`else
  modport master (
    output start, base_addr, stride, num_win, stall,
    input  addr, win_valid, win_idx, busy, done
  );
  modport slave (
    input  start, base_addr, stride, num_win, stall,
    output addr, win_valid, win_idx, busy, done
  );
`endif
endinterface

// File: rtl/mem_window_sched.sv
// rtl/mem_window_sched.sv - windowed address sequencer for the five-tap Mem_5_out memory
// Optional window bounds check is enabled by defining WIN_BOUND_CHK_EN.
module mem_window_sched #(
  parameter int ADDR_WIDTH   = 4,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int CNT_WIDTH    = 4,
  parameter int STRIDE_WIDTH = 3
) (
  input logic             clk,
  input logic             rst,
  mem_window_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [STRIDE_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]    remaining;
  logic [CNT_WIDTH-1:0]    issue_idx;
  logic [CNT_WIDTH-1:0]    win_idx_q;
  logic                    win_valid_q;
  logic                    busy_q;
  logic                    done_q;

`ifdef WIN_BOUND_CHK_EN
  localparam int FULL_W = ADDR_WIDTH + CNT_WIDTH + STRIDE_WIDTH;

  logic              err_q;
  logic [FULL_W-1:0] win_end;
  logic              out_of_bounds;

  // Last word touched by the final window: its base plus the four extra taps.
  assign win_end = FULL_W'(bus.base_addr)
                 + FULL_W'(bus.num_win - CNT_WIDTH'(1)) * FULL_W'(bus.stride)
                 + FULL_W'(4);
  assign out_of_bounds = win_end > FULL_W'(RAM_DEPTH - 1);
  assign bus.err = err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      remaining   <= '0;
      issue_idx   <= '0;
      win_idx_q   <= '0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef WIN_BOUND_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef WIN_BOUND_CHK_EN
      err_q       <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.num_win == '0) begin
              done_q <= 1'b1;
            end
`ifdef WIN_BOUND_CHK_EN
            else if (out_of_bounds) begin
              err_q <= 1'b1;
            end
`endif
            else begin
              state     <= S_RUN;
              busy_q    <= 1'b1;
              addr_q    <= bus.base_addr;
              stride_q  <= bus.stride;
              remaining <= bus.num_win;
              issue_idx <= '0;
            end
          end
        end
        S_RUN: begin
          // win_valid lags the issue by one cycle to line up with the registered read.
          if (!bus.stall) begin
            addr_q      <= (addr_q + ADDR_WIDTH'(stride_q)) & ADDR_MASK;
            remaining   <= remaining - CNT_WIDTH'(1);
            issue_idx   <= issue_idx + CNT_WIDTH'(1);
            win_valid_q <= 1'b1;
            win_idx_q   <= issue_idx;
            if (remaining == CNT_WIDTH'(1)) begin
              state  <= S_DRAIN;
              done_q <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr      = addr_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_idx   = win_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mem_window_sched.sv
// tb/tb_mem_window_sched.sv - directed bench for mem_window_sched
module tb_mem_window_sched;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_window_sched_if #(.ADDR_WIDTH(4), .CNT_WIDTH(4), .STRIDE_WIDTH(3)) bus ();

  mem_window_sched #(
    .ADDR_WIDTH(4),
    .RAM_DEPTH(16),
    .CNT_WIDTH(4),
    .STRIDE_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] a, input logic wv,
                         input logic [3:0] idx, input logic bsy, input logic dn);
    chk({tag, ".addr"}, 32'(bus.addr), 32'(a));
    chk({tag, ".win_valid"}, 32'(bus.win_valid), 32'(wv));
    chk({tag, ".win_idx"}, 32'(bus.win_idx), 32'(idx));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
    chk({tag, ".done"}, 32'(bus.done), 32'(dn));
  endtask

  task automatic drive_start(input logic [3:0] b, input logic [2:0] s, input logic [3:0] n);
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.stride    = s;
    bus.num_win   = n;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.stride    = '0;
    bus.num_win   = '0;
    bus.stall     = 1'b0;
    tick();
    tick();
    chk_out("reset", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
`ifdef WIN_BOUND_CHK_EN
    chk("reset.err", 32'(bus.err), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Basic sweep; a conflicting start held during busy must be ignored.
    drive_start(4'd0, 3'd1, 4'd4);
    tick();
    chk_out("basic.e0", 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    drive_start(4'd9, 3'd3, 4'd2);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("basic.e%0d", k + 1), 4'(k + 1), 1'b1, 4'(k), 1'b1, (k == 3));
    end
    bus.start = 1'b0;
    tick();
    chk_out("basic.e5", 4'd4, 1'b0, 4'd3, 1'b0, 1'b0);
    tick();

    // Stall in the second RUN cycle.
    drive_start(4'd2, 3'd2, 4'd3);
    tick();
    bus.start = 1'b0;
    chk_out("stall.e0", 4'd2, 1'b0, 4'd3, 1'b1, 1'b0);
    tick();
    chk_out("stall.e1", 4'd4, 1'b1, 4'd0, 1'b1, 1'b0);
    bus.stall = 1'b1;
    tick();
    bus.stall = 1'b0;
    chk_out("stall.e2", 4'd4, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    chk_out("stall.e3", 4'd6, 1'b1, 4'd1, 1'b1, 1'b0);
    tick();
    chk_out("stall.e4", 4'd8, 1'b1, 4'd2, 1'b1, 1'b1);
    bus.stall = 1'b1;
    tick();
    chk_out("stall.e5", 4'd8, 1'b0, 4'd2, 1'b0, 1'b0);
    bus.stall = 1'b0;

    // Zero-window start.
    drive_start(4'd5, 3'd1, 4'd0);
    tick();
    bus.start = 1'b0;
    chk_out("zero.e0", 4'd8, 1'b0, 4'd2, 1'b0, 1'b1);
    tick();
    chk_out("zero.e1", 4'd8, 1'b0, 4'd2, 1'b0, 1'b0);

`ifndef WIN_BOUND_CHK_EN
    // Address wrap.
    drive_start(4'd14, 3'd1, 4'd3);
    tick();
    bus.start = 1'b0;
    chk_out("wrap.e0", 4'd14, 1'b0, 4'd2, 1'b1, 1'b0);
    tick();
    chk_out("wrap.e1", 4'd15, 1'b1, 4'd0, 1'b1, 1'b0);
    tick();
    chk_out("wrap.e2", 4'd0, 1'b1, 4'd1, 1'b1, 1'b0);
    tick();
    chk_out("wrap.e3", 4'd1, 1'b1, 4'd2, 1'b1, 1'b1);
    tick();
    chk_out("wrap.e4", 4'd1, 1'b0, 4'd2, 1'b0, 1'b0);
`endif

    // Reset abort at win_idx 1, then a clean restart.
    drive_start(4'd3, 3'd1, 4'd4);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk_out("abort.pre", 4'd5, 1'b1, 4'd1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk_out("abort.rst", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk_out("abort.post", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    drive_start(4'd5, 3'd3, 4'd2);
    tick();
    bus.start = 1'b0;
    chk_out("restart.e0", 4'd5, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    chk_out("restart.e1", 4'd8, 1'b1, 4'd0, 1'b1, 1'b0);
    tick();
    chk_out("restart.e2", 4'd11, 1'b1, 4'd1, 1'b1, 1'b1);
    tick();
    chk_out("restart.e3", 4'd11, 1'b0, 4'd1, 1'b0, 1'b0);

`ifdef WIN_BOUND_CHK_EN
    // Bounds check: 10+2+4=16 rejected, 9+2+4=15 accepted.
    drive_start(4'd10, 3'd1, 4'd3);
    tick();
    bus.start = 1'b0;
    chk("bound.err_pulse", 32'(bus.err), 32'd1);
    chk_out("bound.rej", 4'd11, 1'b0, 4'd1, 1'b0, 1'b0);
    tick();
    chk("bound.err_clear", 32'(bus.err), 32'd0);
    chk("bound.busy_low", 32'(bus.busy), 32'd0);
    drive_start(4'd9, 3'd1, 4'd3);
    tick();
    bus.start = 1'b0;
    chk("bound.ok_err", 32'(bus.err), 32'd0);
    chk_out("bound.ok.e0", 4'd9, 1'b0, 4'd1, 1'b1, 1'b0);
    tick();
    chk_out("bound.ok.e1", 4'd10, 1'b1, 4'd0, 1'b1, 1'b0);
    tick();
    chk_out("bound.ok.e2", 4'd11, 1'b1, 4'd1, 1'b1, 1'b0);
    tick();
    chk_out("bound.ok.e3", 4'd12, 1'b1, 4'd2, 1'b1, 1'b1);
    tick();
    chk_out("bound.ok.e4", 4'd12, 1'b0, 4'd2, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_window_sched.md
# mem_window_sched

Address sequencer for the five-tap windowed weight/activation memory (`Mem_5_out`) in the DNN datapath. Given a base address, stride and window count, it walks the memory's `addr` input one window per cycle. It emits a `win_valid` strobe and window index aligned with the memory's one-cycle registered read, so the downstream MAC stage can consume `data_out_0..4` directly. It supports consumer backpressure and a start/busy/done handshake toward the layer controller.

## Interface
- `ADDR_WIDTH`, 4, memory address width; must match the memory instance.
- `RAM_DEPTH`, `1 << ADDR_WIDTH`, memory depth in words.
- `CNT_WIDTH`, 4, width of the window count and window index.
- `STRIDE_WIDTH`, 3, width of the stride input.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a sweep; sampled only when `busy`=0.
- `base_addr` in ADDR_WIDTH: first window address; latched on accepted `start`.
- `stride` in STRIDE_WIDTH: address increment between windows; latched on accepted `start`.
- `num_win` in CNT_WIDTH: number of windows; latched on accepted `start`.
- `stall` in 1: consumer backpressure; suppresses issuing a new address this cycle.
- `addr` out ADDR_WIDTH: drives the memory `addr`; registered.
- `win_valid` out 1: memory outputs hold window `win_idx` this cycle.
- `win_idx` out CNT_WIDTH: index of the window currently on the memory outputs.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at the end of a sweep.
- `err` out 1: present only with `WIN_BOUND_CHK_EN` (see Configuration).

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `busy`=0 and `addr` holds its last value.
  - `start`=1 with `num_win`≠0 latches the inputs, sets `addr`←`base_addr` and `remaining`←`num_win`, then moves to RUN.
  - `start`=1 with `num_win`=0 stays in IDLE and pulses `done` the next cycle. `win_valid` stays 0.
- **RUN:**
  - Issue is defined as `issue` = RUN & !`stall`.
  - On each issue: `addr`←`addr`+`stride`, `remaining`←`remaining`−1, `issue_idx`←`issue_idx`+1.
  - The cycle that issues with `remaining`=1 moves to DRAIN.
  - While `stall`=1, `addr`, `remaining` and `issue_idx` hold.
- **DRAIN:** lasts exactly one cycle, then returns to IDLE.
- **Strobes:**
  - `win_valid`←`issue` (registered), so it matches the memory's one-cycle read latency.
  - `win_idx`←`issue_idx` on issue.
- **`done`:** asserts in the DRAIN cycle, coincident with the last `win_valid`.
- **Address arithmetic:**
  - Addresses are modulo 2^ADDR_WIDTH and wrap silently.
  - `stride`=0 re-reads `base_addr` `num_win` times.
- **Ignored inputs:** `start` while `busy`=1 is ignored. `stall` outside RUN has no effect.
- **Reset:** `rst` mid-sweep aborts immediately. All state returns to IDLE, no `done` is produced, and all outputs go to reset values.

## Timing
- **Reset values:** `addr`=0, `win_valid`=0, `win_idx`=0, `busy`=0, `done`=0, `err`=0. State is IDLE.
- **Sweep timeline** (`start` sampled at edge E0, N windows, no stall):
  - `addr`=`base_addr` from E0.
  - `busy`=1 from E0 through E(N+1).
  - `win_valid`=1 in the N cycles following E1 through EN.
  - `done`=1 in the cycle following EN, coincident with the last `win_valid`.
  - `busy` falls at E(N+1).
- **Stall:** each stalled RUN cycle delays all subsequent events by one cycle. `win_valid` is 0 in the cycle after a stalled cycle, and the memory data stays stable because `addr` holds.
- **Start latency:** minimum start-to-first-`win_valid` is 2 cycles. A back-to-back `start` is accepted at the first edge with `busy`=0.

## Configuration
- **Macro:** `WIN_BOUND_CHK_EN`.
- **With the macro defined:**
  - The `err` port exists.
  - On `start` with `num_win`≠0, the block computes `base_addr`+(`num_win`−1)·`stride`+4 at full precision (ADDR_WIDTH+CNT_WIDTH+STRIDE_WIDTH bits).
  - If the result exceeds `RAM_DEPTH`−1, `err` pulses for one cycle and the block stays in IDLE with no `done`.
  - Otherwise the sweep proceeds normally.
- **Without the macro:** the `err` port is absent and no check is made. Address wrap is the defined behaviour.

## Test plan
- **Basic sweep:** `base_addr`=0, `stride`=1, `num_win`=4, no stall → `addr` sequence 0,1,2,3; `win_valid` for 4 cycles with `win_idx` 0..3; `done` coincident with `win_idx`=3; `busy` high for 5 cycles.
- **Stall:** `base_addr`=2, `stride`=2, `num_win`=3, `stall` high in the second RUN cycle → `addr` 2,4,4,6; `win_valid` pattern 1,0,1,1; `done` one cycle later than the unstalled case.
- **Edge starts:** `num_win`=0 → `done` pulse one cycle later, `win_valid` never asserted. `start` asserted while `busy`=1 → ignored; the sweep completes unchanged.
- **Wrap (macro off):** `base_addr`=14, `stride`=1, `num_win`=3 → `addr` 14,15,0; 3 valid windows.
- **Reset abort:** `rst` pulsed mid-sweep at `win_idx`=1 → all outputs 0 in the same cycle and no `done`. A new `start` afterwards runs cleanly from its `base_addr`.
- **Bounds check (macro on):** `base_addr`=10, `stride`=1, `num_win`=3 (10+2+4=16>15) → `err` pulses for one cycle and `busy` stays 0. `base_addr`=9 (9+2+4=15) → normal sweep.
